// File: rtl/cache_line_ctrl.sv
// cache_line_ctrl: direct-mapped, write-through, no-write-allocate cache
// sequencer. It keeps the tag/valid state, drives the byte-lane data RAM
// (1-cycle synchronous read, cwait holds the read output) and refills whole
// lines over a request/ack system bus.
module cache_line_ctrl #(
  parameter int datawidth   = 64,
  parameter int cache_depth = 2048,
  parameter int line_words  = 4,
  parameter int paddr_wid   = 32,
  parameter int cswidth     = datawidth / 8,
  parameter int addr_wid    = $clog2(cache_depth),
  parameter int addr_lsb    = $clog2(cswidth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [paddr_wid-1:0] cpu_addr,
  input  logic [datawidth-1:0] cpu_wdata,
  input  logic [cswidth-1:0]   cpu_bsel,
  output logic [datawidth-1:0] cpu_rdata,
  output logic                 cpu_ack,
  input  logic                 inv,
  output logic [addr_wid-1:0]  ram_raddr,
  output logic [addr_wid-1:0]  ram_waddr,
  output logic [datawidth-1:0] ram_di,
  output logic                 ram_we,
  output logic [cswidth-1:0]   ram_bsel,
  output logic                 ram_cwait,
  input  logic [datawidth-1:0] ram_dato,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [paddr_wid-1:0] bus_addr,
  output logic [datawidth-1:0] bus_wdata,
  output logic [cswidth-1:0]   bus_bsel,
  input  logic [datawidth-1:0] bus_rdata,
  input  logic                 bus_ack
);

  localparam int off_w = $clog2(line_words);
  localparam int idx_w = addr_wid - off_w;
  localparam int tag_w = paddr_wid - addr_lsb - addr_wid;
  localparam int sets  = cache_depth / line_words;
  localparam int wa_w  = paddr_wid - addr_lsb;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] WTHRU  = 3'd2;
  localparam logic [2:0] REFILL = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [off_w-1:0] last_cnt = off_w'(line_words - 1);

  logic [2:0]           state_reg;
  logic                 inv_pend_reg;
  logic [wa_w-1:0]      word_addr_reg;   // latched CPU address without byte offset
  logic [datawidth-1:0] wdata_reg;
  logic [datawidth-1:0] rdata_q_reg;
  logic [cswidth-1:0]   bsel_reg;
  logic                 we_reg;
  logic [off_w-1:0]     cnt_reg;
  logic [sets-1:0]      valid_reg;
  logic [tag_w-1:0]     tag_mem [sets];
  logic [tag_w-1:0]     tag_rd_reg;

  logic [addr_wid-1:0]  cpu_word;
  logic [idx_w-1:0]     cpu_idx;
  logic [addr_wid-1:0]  word_reg;
  logic [idx_w-1:0]     idx_reg;
  logic [off_w-1:0]     off_reg;
  logic [tag_w-1:0]     tag_reg;
  logic [off_w-1:0]     cnt_inc;
  logic                 accept;
  logic                 inv_clr;
  logic                 beat;
  logic                 fill_done;
  logic                 hit;
  logic                 unused_lsbs;

  assign cpu_word = cpu_addr[addr_lsb+addr_wid-1:addr_lsb];
  assign cpu_idx  = cpu_word[addr_wid-1:off_w];
  assign word_reg = word_addr_reg[addr_wid-1:0];
  assign idx_reg  = word_reg[addr_wid-1:off_w];
  assign off_reg  = word_reg[off_w-1:0];
  assign tag_reg  = word_addr_reg[wa_w-1:addr_wid];
  assign cnt_inc  = cnt_reg + 1'b1;

  // Byte offset never reaches the bus or the RAM: everything is word granular.
  assign unused_lsbs = ^cpu_addr[addr_lsb-1:0];

  // No new accept during the ack cycle: the CPU still holds cpu_req there.
  assign accept    = (state_reg == IDLE) && cpu_req && !cpu_ack && !inv &&
                     !inv_pend_reg && !rst;
  assign inv_clr   = (state_reg == IDLE) && (inv || inv_pend_reg);
  assign beat      = bus_req && bus_ack;
  assign fill_done = (state_reg == REFILL) && beat && (cnt_reg == last_cnt);
  assign hit       = valid_reg[idx_reg] && (tag_rd_reg == tag_reg);

  // RAM read is issued in the accept cycle so data is ready during LOOKUP;
  // otherwise the read port holds its output.
  assign ram_raddr = accept ? cpu_word : word_reg;
  assign ram_cwait = !accept;

  // Tag array: written when a refill lands, read alongside the data RAM on accept
  always_ff @(posedge clk) begin
    if (fill_done) tag_mem[idx_reg] <= tag_reg;
    if (accept)    tag_rd_reg       <= tag_mem[cpu_idx];
  end

  genvar gi;
  generate
    for (gi = 0; gi < sets; gi++) begin : g_valid
      // One valid flag per line: cleared by invalidate, set when its refill lands
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         valid_reg[gi] <= 1'b0;
        else if (inv_clr)                                valid_reg[gi] <= 1'b0;
        else if (fill_done && (idx_reg == idx_w'(gi)))   valid_reg[gi] <= 1'b1;
      end
    end
  endgenerate

  // Request sequencing, bus handshakes and registered CPU/RAM/bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      inv_pend_reg  <= 1'b0;
      word_addr_reg <= '0;
      wdata_reg     <= '0;
      rdata_q_reg   <= '0;
      bsel_reg      <= '0;
      we_reg        <= 1'b0;
      cnt_reg       <= '0;
      cpu_rdata     <= '0;
      cpu_ack       <= 1'b0;
      ram_waddr     <= '0;
      ram_di        <= '0;
      ram_we        <= 1'b0;
      ram_bsel      <= '0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_bsel      <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ram_we  <= 1'b0;
      if (inv && (state_reg != IDLE)) inv_pend_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (inv_clr) begin
            inv_pend_reg <= 1'b0;
          end else if (accept) begin
            word_addr_reg <= cpu_addr[paddr_wid-1:addr_lsb];
            wdata_reg     <= cpu_wdata;
            bsel_reg      <= cpu_bsel;
            we_reg        <= cpu_we;
            state_reg     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!we_reg) begin
            if (hit) begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= ram_dato;
              state_reg <= IDLE;
            end else begin
              // Refill always walks the line from offset 0.
              cnt_reg   <= '0;
              bus_req   <= 1'b1;
              bus_we    <= 1'b0;
              bus_bsel  <= '1;
              bus_addr  <= {tag_reg, idx_reg, {off_w{1'b0}}, {addr_lsb{1'b0}}};
              state_reg <= REFILL;
            end
          end else begin
            // Write-through: update the RAM only on a hit, always go to the bus.
            if (hit) begin
              ram_we    <= 1'b1;
              ram_waddr <= word_reg;
              ram_di    <= wdata_reg;
              ram_bsel  <= bsel_reg;
            end
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= {word_addr_reg, {addr_lsb{1'b0}}};
            bus_wdata <= wdata_reg;
            bus_bsel  <= bsel_reg;
            state_reg <= WTHRU;
          end
        end
        WTHRU: begin
          if (beat) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            cpu_ack   <= 1'b1;
            state_reg <= IDLE;
          end
        end
        REFILL: begin
          if (beat) begin
            ram_we    <= 1'b1;
            ram_waddr <= {idx_reg, cnt_reg};
            ram_di    <= bus_rdata;
            ram_bsel  <= '1;
            if (cnt_reg == off_reg) rdata_q_reg <= bus_rdata;
            cnt_reg   <= cnt_inc;
            bus_addr  <= {tag_reg, idx_reg, cnt_inc, {addr_lsb{1'b0}}};
            if (cnt_reg == last_cnt) begin
              bus_req   <= 1'b0;
              state_reg <= RESP;
            end
          end
        end
        RESP: begin
          cpu_ack   <= 1'b1;
          cpu_rdata <= rdata_q_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// tb_cache_line_ctrl: directed plus randomized load/store traffic against a
// behavioural cache/memory model; RAM and system bus are modelled here.
module tb_cache_line_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, inv;
  logic [31:0] cpu_addr;
  logic [63:0] cpu_wdata, cpu_rdata;
  logic [7:0]  cpu_bsel;
  logic        cpu_ack;
  logic [10:0] ram_raddr, ram_waddr;
  logic [63:0] ram_di, ram_dato;
  logic        ram_we, ram_cwait;
  logic [7:0]  ram_bsel;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr;
  logic [63:0] bus_wdata, bus_rdata;
  logic [7:0]  bus_bsel;

  int checks = 0;
  int errors = 0;

  typedef struct { logic we; logic [31:0] addr; logic [63:0] wdata; logic [7:0] bsel; } bus_rec_t;
  typedef struct { logic [10:0] waddr; logic [63:0] di; logic [7:0] bsel; } ram_rec_t;
  bus_rec_t bus_log[$];
  ram_rec_t ram_log[$];

  logic [63:0] ram_m   [2048];
  logic [63:0] sys_mem [16384];
  logic [63:0] mdl_mem [16384];
  bit          mdl_valid [512];
  int          mdl_tag   [512];
  int          slv_wait;

  always #5 clk = ~clk;

  cache_line_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_bsel(cpu_bsel), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .inv(inv),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_di(ram_di), .ram_we(ram_we),
    .ram_bsel(ram_bsel), .ram_cwait(ram_cwait), .ram_dato(ram_dato),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_bsel(bus_bsel), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  function automatic logic [13:0] key(input logic [31:0] a);
    return {a[31], a[15:3]};
  endfunction

  function automatic logic [63:0] init_val(input logic [13:0] k);
    logic [31:0] kk;
    kk = {18'd0, k};
    return {32'hC0DE_0000 + kk, 32'h1234_5678 ^ (kk * 32'h0000_9E37)};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] bs);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (bs[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Cache data RAM: synchronous byte-lane write, 1-cycle read held while cwait=1
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 8; b++)
        if (ram_bsel[b]) ram_m[ram_waddr][b*8 +: 8] <= ram_di[b*8 +: 8];
      ram_log.push_back('{ram_waddr, ram_di, ram_bsel});
    end
    if (!ram_cwait) ram_dato <= ram_m[ram_waddr == ram_raddr && ram_we ? ram_raddr : ram_raddr];
  end

  // System bus slave: random 0..2 cycle wait, one-cycle ack per beat
  always @(posedge clk) begin
    if (bus_ack) begin
      bus_ack <= 1'b0;
    end else if (bus_req) begin
      if (slv_wait == 0) begin
        bus_ack   <= 1'b1;
        bus_rdata <= sys_mem[key(bus_addr)];
        if (bus_we) sys_mem[key(bus_addr)] <= merge(sys_mem[key(bus_addr)], bus_wdata, bus_bsel);
        bus_log.push_back('{bus_we, bus_addr, bus_wdata, bus_bsel});
        slv_wait <= $urandom_range(0, 2);
      end else begin
        slv_wait <= slv_wait - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request and wait (bounded) for cpu_ack; optionally pulse inv
  // or assert reset once the given number of bus beats have completed.
  task automatic drive(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [7:0] bs, input int inv_beat, input int rst_beat,
                       output logic [63:0] rd, output int lat, output bit acked);
    int  beats;
    bit  inv_done;
    beats = 0; inv_done = 0; acked = 0; rd = '0; lat = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_bsel = bs;
    for (int c = 0; c < 300 && !acked; c++) begin
      @(negedge clk);
      lat++;
      inv = 1'b0;
      if (bus_req && bus_ack) beats++;
      if (rst_beat > 0 && beats == rst_beat) begin
        rst = 1'b1;
        cpu_req = 1'b0;
        return;
      end
      if (inv_beat > 0 && beats == inv_beat && !inv_done) begin
        inv = 1'b1;
        inv_done = 1;
      end
      if (cpu_ack) begin
        acked = 1;
        rd = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    inv = 1'b0;
  endtask

  // One transaction with model-predicted hit/miss, bus traffic, RAM writes and data
  task automatic run_op(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                        input logic [7:0] bs, input int inv_beat);
    int          set, tg, lat;
    bit          hit, ok;
    logic [31:0] aw, base;
    logic [63:0] rd, exp_rd;
    set  = int'((addr / 32) % 512);
    tg   = int'(addr / 16384);
    hit  = mdl_valid[set] && (mdl_tag[set] == tg);
    aw   = addr & 32'hFFFF_FFF8;
    base = addr & 32'hFFFF_FFE0;
    bus_log.delete();
    ram_log.delete();
    drive(we, addr, wd, bs, inv_beat, 0, rd, lat, ok);
    check("ack_seen", 64'(ok), 64'd1);
    if (!we) begin
      exp_rd = mdl_mem[key(aw)];
      check("load_data", rd, exp_rd);
      check("refill_beats", 64'(bus_log.size()), hit ? 64'd0 : 64'd4);
      check("ram_fill_writes", 64'(ram_log.size()), hit ? 64'd0 : 64'd4);
      if (hit) check("hit_latency", 64'(lat), 64'd2);
      for (int i = 0; i < 4; i++) begin
        if (!hit && bus_log.size() > i) begin
          check($sformatf("beat%0d_addr", i), 64'(bus_log[i].addr), 64'(base + 32'(8 * i)));
          check($sformatf("beat%0d_we", i), 64'(bus_log[i].we), 64'd0);
        end
        if (!hit && ram_log.size() > i) begin
          check($sformatf("fill%0d_waddr", i), 64'(ram_log[i].waddr), 64'(((base / 8) % 2048) + 32'(i)));
          check($sformatf("fill%0d_data", i), ram_log[i].di, mdl_mem[key(base + 32'(8 * i))]);
          check($sformatf("fill%0d_bsel", i), 64'(ram_log[i].bsel), 64'hFF);
        end
      end
      if (!hit) begin
        mdl_valid[set] = 1;
        mdl_tag[set]   = tg;
      end
      if (inv_beat > 0) for (int s = 0; s < 512; s++) mdl_valid[s] = 0;
    end else begin
      mdl_mem[key(aw)] = merge(mdl_mem[key(aw)], wd, bs);
      check("store_bus_writes", 64'(bus_log.size()), 64'd1);
      if (bus_log.size() > 0) begin
        check("store_bus_we", 64'(bus_log[0].we), 64'd1);
        check("store_bus_addr", 64'(bus_log[0].addr), 64'(aw));
        check("store_bus_wdata", bus_log[0].wdata, wd);
        check("store_bus_bsel", 64'(bus_log[0].bsel), 64'(bs));
      end
      check("store_ram_writes", 64'(ram_log.size()), hit ? 64'd1 : 64'd0);
      if (hit && ram_log.size() > 0) begin
        check("store_ram_waddr", 64'(ram_log[0].waddr), 64'((aw / 8) % 2048));
        check("store_ram_bsel", 64'(ram_log[0].bsel), 64'(bs));
        check("store_ram_word", ram_m[(aw / 8) % 2048], mdl_mem[key(aw)]);
      end
    end
    $display("op we=%0d addr=%h hit=%0d rdata=%h lat=%0d beats=%0d", we, addr, hit, rd, lat,
             bus_log.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rd;
    int          lat, acks;
    bit          ok;
    logic [31:0] a;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_bsel = '0; inv = 1'b0; bus_ack = 1'b0; bus_rdata = '0; ram_dato = '0; slv_wait = 0;
    for (int i = 0; i < 2048; i++) ram_m[i] = '0;
    for (int k = 0; k < 16384; k++) begin
      sys_mem[k] = init_val(14'(k));
      mdl_mem[k] = init_val(14'(k));
    end
    for (int s = 0; s < 512; s++) begin
      mdl_valid[s] = 0;
      mdl_tag[s]   = 0;
    end

    repeat (3) @(negedge clk);
    check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_bus_we", 64'(bus_we), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_cwait", 64'(ram_cwait), 64'd1);
    check("rst_bus_addr", 64'(bus_addr), 64'd0);
    check("rst_ram_raddr", 64'(ram_raddr), 64'd0);
    check("rst_cpu_rdata", cpu_rdata, 64'd0);
    rst = 1'b0;

    // Line fill, hit, store hit with partial lanes, merged reload
    run_op(1'b0, 32'h0000_1008, '0, '0, 0);
    for (int i = 0; i < 4; i++)
      check($sformatf("ram_word_%0h", 32'h200 + i), ram_m[32'h200 + i], mdl_mem[key(32'h1000 + 32'(8 * i))]);
    run_op(1'b0, 32'h0000_1008, '0, '0, 0);
    run_op(1'b1, 32'h0000_1010, 64'h1122_3344_5566_7788, 8'h0F, 0);
    run_op(1'b0, 32'h0000_1010, '0, '0, 0);

    // Store miss (no allocate), then load of the same address refills
    run_op(1'b1, 32'h9000_0000, 64'hDEAD_BEEF_0BAD_F00D, 8'hF0, 0);
    run_op(1'b0, 32'h9000_0000, '0, '0, 0);

    // Tag conflict on the same index evicts the line
    run_op(1'b0, 32'h0000_1000, '0, '0, 0);
    run_op(1'b0, 32'h0000_5000, '0, '0, 0);
    run_op(1'b0, 32'h0000_1000, '0, '0, 0);

    // Random traffic over a few conflicting sets and tags
    for (int n = 0; n < 40; n++) begin
      int s_sel;
      s_sel = $urandom_range(0, 2);
      a = (32'($urandom_range(0, 3)) << 14) | (32'(32'h7F + s_sel) << 5) |
          (32'($urandom_range(0, 3)) << 3) | 32'($urandom_range(0, 7));
      run_op(($urandom_range(0, 2) == 0), a, {$urandom, $urandom}, 8'($urandom), 0);
    end

    // Invalidate during a refill: that line lands, then everything is invalid
    run_op(1'b0, 32'h0000_3008, '0, '0, 1);
    run_op(1'b0, 32'h0000_3008, '0, '0, 0);

    // Reset on beat 2 of a refill abandons it
    bus_log.delete();
    drive(1'b0, 32'h0000_1008, '0, '0, 0, 2, rd, lat, ok);
    check("rst_mid_refill_no_ack", 64'(ok), 64'd0);
    @(negedge clk);
    check("rst_mid_bus_req", 64'(bus_req), 64'd0);
    check("rst_mid_cpu_ack", 64'(cpu_ack), 64'd0);
    check("rst_mid_ram_cwait", 64'(ram_cwait), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack || bus_req) acks++;
    end
    check("post_rst_quiet", 64'(acks), 64'd0);
    $display("op reset_mid_refill addr=00001008 beats_before_reset=%0d", bus_log.size());
    for (int s = 0; s < 512; s++) mdl_valid[s] = 0;
    run_op(1'b0, 32'h0000_1008, '0, '0, 0);
    run_op(1'b0, 32'h0000_1008, '0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
